z80_bus_arbiter: RTL

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

---
 rtl/z80_arb_pkg.sv | 17 +
 rtl/z80_arb_timer.sv | 27 ++
 rtl/z80_bus_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/z80_arb_pkg.sv
// Shared state encoding and counter widths for the Z80 bus arbiter.
package z80_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t StIdle    = 3'd0;
  localparam arb_state_t StReq     = 3'd1;
  localparam arb_state_t StSetup   = 3'd2;
  localparam arb_state_t StStrobe  = 3'd3;
  localparam arb_state_t StHold    = 3'd4;
  localparam arb_state_t StGap     = 3'd5;
  localparam arb_state_t StRelease = 3'd6;

  localparam int unsigned WaitCntW = 4;
  localparam int unsigned ToCntW   = 8;

endpackage

// File: rtl/z80_arb_timer.sv
// Loadable down-counter shared by the strobe wait count and the BUSAK timeout.
module z80_arb_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Borrows the Z80 bus through BUSRQ/BUSAK to run single or burst DMA accesses.
// Define Z80_ARB_TIMEOUT_EN to abandon a request the Z80 never acknowledges.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_err,
  output logic        dma_grant,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_mreq_n,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic [7:0]  mem_rdata
);

`ifdef Z80_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = ToCntW;
`else
  localparam int unsigned TimerW = WaitCntW;
`endif

  arb_state_t        state_q, state_d;
  logic [7:0]        rdata_q;
  logic              capture;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;
  logic [TimerW-1:0] tmr_val;
`ifdef Z80_ARB_TIMEOUT_EN
  logic              timeout;
`endif

  z80_arb_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
`ifdef Z80_ARB_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (dma_req) begin
          state_d = StReq;
`ifdef Z80_ARB_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TimerW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      StReq: begin
        // Acknowledge wins over a same-cycle abort or timeout.
        if (!cpu_busak_n) begin
          state_d = StSetup;
        end else if (!dma_req) begin
          state_d = StRelease;
`ifdef Z80_ARB_TIMEOUT_EN
        end else if (tmr_zero) begin
          state_d = StRelease;
          timeout = 1'b1;
        end else begin
          tmr_dec = 1'b1;
`endif
        end
      end
      StSetup: begin
        state_d  = StStrobe;
        tmr_load = 1'b1;
        tmr_val  = TimerW'(WAIT_STATES);
      end
      StStrobe: begin
        if (tmr_zero) begin
          state_d = StHold;
          capture = !dma_we;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StHold:    state_d = StGap;
      StGap:     state_d = dma_req ? StSetup : StRelease;
      StRelease: begin
        if (cpu_busak_n) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Memory side follows the Z80 unless the arbiter owns or is still handing back the bus.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_dout;
    mem_mreq_n = cpu_mreq_n;
    mem_rd_n   = cpu_rd_n;
    mem_wr_n   = cpu_wr_n;
    case (state_q)
      StSetup: begin
        mem_addr   = dma_addr;
        mem_wdata  = dma_wdata;
        mem_mreq_n = 1'b0;
        mem_rd_n   = 1'b1;
        mem_wr_n   = 1'b1;
      end
      StStrobe: begin
        mem_addr   = dma_addr;
        mem_wdata  = dma_wdata;
        mem_mreq_n = 1'b0;
        mem_rd_n   = dma_we;
        mem_wr_n   = !dma_we;
      end
      StHold, StGap: begin
        mem_addr   = dma_addr;
        mem_wdata  = dma_wdata;
        mem_mreq_n = 1'b1;
        mem_rd_n   = 1'b1;
        mem_wr_n   = 1'b1;
      end
      StRelease: begin
        if (!cpu_busak_n) begin
          mem_mreq_n = 1'b1;
          mem_rd_n   = 1'b1;
          mem_wr_n   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cpu_busrq_n = (state_q == StIdle) || (state_q == StRelease);
  assign dma_grant   = (state_q == StSetup) || (state_q == StStrobe) ||
                       (state_q == StHold)  || (state_q == StGap);
  assign dma_ack     = (state_q == StHold);
  assign dma_rdata   = rdata_q;

`ifdef Z80_ARB_TIMEOUT_EN
  assign dma_err = timeout;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign dma_err = 1'b0;
`endif

endmodule
